// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Moore-style sequencer for a shared-resource multicycle MIPS datapath
//   (one ALU, one unified memory, IR/MDR/A/B/ALUOut registers). Walks each
//   instruction through fetch, decode, execute, memory and writeback states,
//   stalls on the memory-ready handshake and counts retired instructions.
//
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   run                 level; leaves IDLE when high, sampled in FETCH
//   opcode[5:0]         IR[31:26], valid from DECODE onward
//   mem_ready           memory completes the current access this cycle
//   pc_write            unconditional PC load
//   pc_write_cond       PC load if ALU zero
//   iord                memory address select (0=PC, 1=ALUOut)
//   mem_read/mem_write  memory requests
//   ir_write            load IR from memory data
//   mem_to_reg          writeback source (1=MDR, 0=ALUOut)
//   reg_dst             destination register select (1=rd, 0=rt)
//   reg_write           register file write enable
//   alu_src_a           ALU A select (0=PC, 1=A)
//   alu_src_b[1:0]      ALU B select (0=B, 1=4, 2=signext, 3=signext<<2)
//   alu_op[1:0]         0=add, 1=sub, 2=funct-decoded
//   pc_source[1:0]      0=ALU result, 1=ALUOut, 2=jump target
//   state[3:0]          current state encoding
//   illegal             one-cycle pulse in DECODE on an unknown opcode
//   retired             completed instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] FETCH  = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] MEMADR = 4'd3;
    localparam logic [3:0] MEMRD  = 4'd4;
    localparam logic [3:0] MEMWB  = 4'd5;
    localparam logic [3:0] MEMWR  = 4'd6;
    localparam logic [3:0] EXEC   = 4'd7;
    localparam logic [3:0] RWB    = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] JUMP   = 4'd10;
    localparam logic [3:0] ADDIEX = 4'd11;
    localparam logic [3:0] ADDIWB = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0] next_state;
    logic       retire_event;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (run) next_state = FETCH;
            FETCH: begin
                // run is only honoured before the fetch completes; a fetched
                // instruction always runs to the end.
                if (mem_ready)    next_state = DECODE;
                else if (!run)    next_state = IDLE;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      next_state = EXEC;
                    OP_LW, OP_SW:  next_state = MEMADR;
                    OP_BEQ:        next_state = BRANCH;
                    OP_J:          next_state = JUMP;
                    OP_ADDI:       next_state = ADDIEX;
                    default:       next_state = FETCH;
                endcase
            end
            MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) next_state = MEMWB;
            MEMWR:  if (mem_ready) next_state = FETCH;
            EXEC:   next_state = RWB;
            ADDIEX: next_state = ADDIWB;
            MEMWB, RWB, BRANCH, JUMP, ADDIWB: next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Retirement is the return to FETCH from a terminal state; an illegal
    // opcode returns from DECODE and is deliberately not counted.
    always_comb begin
        retire_event = 1'b0;
        if (next_state == FETCH) begin
            case (state)
                MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB: retire_event = 1'b1;
                default:                                 retire_event = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            retired <= '0;
        end else begin
            state <= next_state;
            if (retire_event) retired <= retired + RETIRE_W'(1);
        end
    end

    // Outputs decode from state alone (the async reset forces IDLE, hence all
    // zeros, without a clock edge). FETCH qualifies ir_write/pc_write with
    // mem_ready so IR and PC update only on the completing cycle.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        illegal       = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
                    default:                                       illegal = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            ADDIWB: reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed self-checking bench for multicycle_control. Instantiated with a
//   3-bit retired counter so the wrap from 7 to 0 is reachable.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal;
    logic [2:0]  retired;

    int compared   = 0;
    int mismatched = 0;

    multicycle_control #(.RETIRE_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .state(state),
        .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    logic [15:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source};

    function automatic logic [15:0] ctl(
        input logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa,
        input logic [1:0] asb, aop, psrc);
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    // Hand-derived control words per state.
    logic [15:0] c_idle, c_fetch_rdy, c_fetch_wait, c_decode, c_memadr, c_memrd;
    logic [15:0] c_memwb, c_memwr, c_exec, c_rwb, c_branch, c_jump, c_addiex, c_addiwb;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expect_state(input string tag, input logic [3:0] st,
                                input logic [15:0] c);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        c_idle       = '0;
        c_fetch_rdy  = ctl(1,0,0,1,0,1,0,0,0,0,2'd1,2'd0,2'd0);
        c_fetch_wait = ctl(0,0,0,1,0,0,0,0,0,0,2'd1,2'd0,2'd0);
        c_decode     = ctl(0,0,0,0,0,0,0,0,0,0,2'd3,2'd0,2'd0);
        c_memadr     = ctl(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0);
        c_memrd      = ctl(0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,2'd0);
        c_memwb      = ctl(0,0,0,0,0,0,1,0,1,0,2'd0,2'd0,2'd0);
        c_memwr      = ctl(0,0,1,0,1,0,0,0,0,0,2'd0,2'd0,2'd0);
        c_exec       = ctl(0,0,0,0,0,0,0,0,0,1,2'd0,2'd2,2'd0);
        c_rwb        = ctl(0,0,0,0,0,0,0,1,1,0,2'd0,2'd0,2'd0);
        c_branch     = ctl(0,1,0,0,0,0,0,0,0,1,2'd0,2'd1,2'd1);
        c_jump       = ctl(1,0,0,0,0,0,0,0,0,0,2'd0,2'd0,2'd2);
        c_addiex     = ctl(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0);
        c_addiwb     = ctl(0,0,0,0,0,0,0,0,1,0,2'd0,2'd0,2'd0);

        // Reset state.
        reset_n = 1'b0; run = 1'b0; opcode = 6'b0; mem_ready = 1'b0;
        #12;
        expect_state("reset", 4'd0, c_idle);
        check("reset.retired", 32'(retired), 32'd0);
        check("reset.illegal", 32'(illegal), 32'd0);

        // lw with memory always ready: 0,1,2,3,4,5,1.
        reset_n = 1'b1; run = 1'b1; opcode = 6'b100011; mem_ready = 1'b1;
        step(); expect_state("lw.fetch", 4'd1, c_fetch_rdy);
        step(); expect_state("lw.decode", 4'd2, c_decode);
        step(); expect_state("lw.memadr", 4'd3, c_memadr);
        step(); expect_state("lw.memrd", 4'd4, c_memrd);
        step(); expect_state("lw.memwb", 4'd5, c_memwb);
        step(); expect_state("lw.done", 4'd1, c_fetch_rdy);
        check("lw.retired", 32'(retired), 32'd1);

        // sw with mem_ready low for 3 cycles in MEMWR.
        opcode = 6'b101011;
        step(); expect_state("sw.decode", 4'd2, c_decode);
        step(); expect_state("sw.memadr", 4'd3, c_memadr);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_state("sw.memwr_wait", 4'd6, c_memwr);
        end
        mem_ready = 1'b1;
        #1 expect_state("sw.memwr_ready", 4'd6, c_memwr);
        check("sw.retired_before", 32'(retired), 32'd1);
        step(); expect_state("sw.done", 4'd1, c_fetch_rdy);
        check("sw.retired", 32'(retired), 32'd2);

        // beq, j, R-type back-to-back: 10 cycles, three retirements.
        opcode = 6'b000100;
        step(); expect_state("beq.decode", 4'd2, c_decode);
        step(); expect_state("beq.branch", 4'd9, c_branch);
        opcode = 6'b000010;
        step(); expect_state("j.fetch", 4'd1, c_fetch_rdy);
        step(); expect_state("j.decode", 4'd2, c_decode);
        step(); expect_state("j.jump", 4'd10, c_jump);
        opcode = 6'b000000;
        step(); expect_state("r.fetch", 4'd1, c_fetch_rdy);
        step(); expect_state("r.decode", 4'd2, c_decode);
        step(); expect_state("r.exec", 4'd7, c_exec);
        step(); expect_state("r.rwb", 4'd8, c_rwb);
        step(); expect_state("r.done", 4'd1, c_fetch_rdy);
        check("bjr.retired", 32'(retired), 32'd5);

        // Unknown opcode: illegal pulse in DECODE, back to FETCH, no retire.
        opcode = 6'b111111;
        step(); expect_state("ill.decode", 4'd2, c_decode);
        check("ill.pulse", 32'(illegal), 32'd1);
        step(); expect_state("ill.fetch", 4'd1, c_fetch_rdy);
        check("ill.pulse_end", 32'(illegal), 32'd0);
        check("ill.retired", 32'(retired), 32'd5);

        // addi, then two jumps so the 3-bit counter wraps 7 -> 0.
        opcode = 6'b001000;
        step(); expect_state("addi.decode", 4'd2, c_decode);
        step(); expect_state("addi.ex", 4'd11, c_addiex);
        step(); expect_state("addi.wb", 4'd12, c_addiwb);
        opcode = 6'b000010;
        step(); check("addi.retired", 32'(retired), 32'd6);
        step(); step();
        step(); check("wrap.retired7", 32'(retired), 32'd7);
        step(); step();
        step(); expect_state("wrap.fetch", 4'd1, c_fetch_rdy);
        check("wrap.retired0", 32'(retired), 32'd0);

        // FETCH stalled 5 cycles: no IR/PC load until the ready cycle.
        mem_ready = 1'b0; opcode = 6'b100011;
        #1 expect_state("stall.0", 4'd1, c_fetch_wait);
        for (int i = 1; i < 5; i++) begin
            step(); expect_state("stall.n", 4'd1, c_fetch_wait);
        end
        mem_ready = 1'b1;
        #1 expect_state("stall.ready", 4'd1, c_fetch_rdy);
        step(); expect_state("stall.decode", 4'd2, c_decode);
        step(); expect_state("rst.memadr", 4'd3, c_memadr);
        mem_ready = 1'b0;
        step(); expect_state("rst.memrd", 4'd4, c_memrd);

        // Async reset mid-MEMRD, checked between clock edges.
        #3 reset_n = 1'b0;
        #1 expect_state("rst.async", 4'd0, c_idle);
        check("rst.retired", 32'(retired), 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);

        // run=0 in FETCH with mem_ready=0 -> IDLE, no memory request.
        #1 reset_n = 1'b1; run = 1'b1; mem_ready = 1'b0;
        step(); expect_state("stop.fetch", 4'd1, c_fetch_wait);
        run = 1'b0;
        #1 expect_state("stop.fetch_run0", 4'd1, c_fetch_wait);
        step(); expect_state("stop.idle", 4'd0, c_idle);
        step(); expect_state("stop.idle_hold", 4'd0, c_idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencer that drives a shared-resource multicycle MIPS datapath: one ALU, one unified memory, and an IR/MDR/A/B/ALUOut register set.
- Replaces the single-cycle opcode decoder. Walks each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
RETIRE_W, 32, width of retired-instruction counter

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
run  input  1  level; leaves IDLE when 1
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
iord  output  1  0=PC addresses memory, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load IR from memory data
mem_to_reg  output  1  writeback source 1=MDR, 0=ALUOut
reg_dst  output  1  1=rd, 0=rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  0=B, 1=const 4, 2=signext, 3=signext<<2
alu_op  output  2  0=add, 1=sub, 2=funct-decoded
pc_source  output  2  0=ALU result, 1=ALUOut, 2=jump target
state  output  4  current state encoding
illegal  output  1  one-cycle pulse on unknown opcode
retired  output  RETIRE_W  completed instruction count

Behaviour:
- Reset (async, reset_n=0): state=IDLE, retired=0, illegal=0. All control outputs are 0 while in IDLE.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
- IDLE: all outputs 0. Goes to FETCH when run=1.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; that is the only Mealy qualification in FETCH.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - anything else -> illegal=1 for that cycle, then FETCH; retired is not incremented.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEMRD if opcode=100011, else MEMWR.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Goes to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=2. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- Returning to IDLE: run=0 is sampled only in FETCH before mem_ready. If run=0 and mem_ready=0 in FETCH, go to IDLE with no memory request in the next cycle. An in-flight instruction always completes.
- retired increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^RETIRE_W.
- Instruction cycle counts with mem_ready=1 always: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3. Each mem_ready=0 cycle adds 1.
- reset_n asserted mid-instruction: immediate return to IDLE, all outputs 0 combinationally. No partial write may occur after reset assertion.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.

Test Plan:
- Reset then run=1, opcode=100011, mem_ready=1 -> states 0,1,2,3,4,5,1. reg_write=1 only in MEMWB with mem_to_reg=1. retired=1.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles, iord=1. Transition to FETCH exactly on the mem_ready cycle.
- beq, then j, then R-type back-to-back -> pc_write_cond only in BRANCH, pc_source=2 only in JUMP, reg_dst=1 in RWB. retired=3 after 10 cycles.
- opcode=111111 -> illegal pulses 1 cycle in DECODE, next state FETCH, retired unchanged.
- mem_ready=0 in FETCH for 5 cycles -> ir_write and pc_write stay 0 until the ready cycle, then both 1 for exactly one cycle.
- reset_n dropped while in MEMRD -> state=0 and all outputs 0 without a clock edge. run=0 in FETCH with mem_ready=0 -> IDLE.
